display_scan_controller: RTL and testbench

- Time-multiplexes NUM_DIGITS 4-bit values onto one shared registered binary-to-7-segment decoder and drives one-hot digit enables for a multi-digit common-segment display.
- Sits between sensor/UART data logic (producer) and the segment decoder plus display pins.
- Double-buffers the display frame so updates never tear mid-scan.
- Inserts a blanking gap per digit that covers the decoder's 1-cycle latency and suppresses ghosting.

---
 rtl/display_scan_controller.sv | 148 ++++++++++++++
 tb/tb_display_scan_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexes NUM_DIGITS nibbles onto one shared segment decoder and
//   drives one-hot digit enables. The frame is double-buffered: the producer
//   loads a staging buffer, which becomes the active frame only at the frame
//   boundary. Each digit is preceded by a blanking gap so the registered
//   decoder settles before its enable rises.
//
// Ports
//   clock, reset   system clock, synchronous active-high reset
//   load           producer strobe, accepted only while load_ready is high
//   load_ready     staging buffer free (no commit pending)
//   data_in        digit k = data_in[4k+3:4k]
//   blank_in       per-digit blank mask, 1 = digit dark
//   load_ack       1-cycle pulse when staged data becomes the active frame
//   binary_number  nibble to the segment decoder
//   digit_enable   one-hot active-high digit drive
//   frame_start    1-cycle pulse on the first BLANK cycle of digit 0
module display_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic                    load_ack,
  output logic [3:0]              binary_number,
  output logic [NUM_DIGITS-1:0]   digit_enable,
  output logic                    frame_start
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state, state_next;
  logic [IW-1:0]           index, index_next;
  logic [CW-1:0]           count, count_next;
  logic                    running;
  logic                    boundary;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] staging_data, active_data, active_data_next;
  logic [NUM_DIGITS-1:0]   staging_mask, active_mask, active_mask_next;
  logic                    commit;
  logic [3:0]              nibble_next;
  logic [NUM_DIGITS-1:0]   enable_next;
  logic                    frame_start_next;

  // The cycle right after reset is an idle step with all outputs dark; the
  // first frame (and its frame_start pulse) begins on the following edge, so
  // the counters stay parked until 'running' is set.
  always_comb begin
    state_next = state;
    index_next = index;
    count_next = count;
    boundary   = 1'b0;
    if (running) begin
      unique case (state)
        BLANK: begin
          if (count == BLANK_LAST) begin
            state_next = SHOW;
            count_next = '0;
          end else begin
            count_next = count + CW'(1);
          end
        end
        SHOW: begin
          if (count == DWELL_LAST) begin
            state_next = BLANK;
            count_next = '0;
            if (index == LAST_DIGIT) begin
              index_next = '0;
              boundary   = 1'b1;
            end else begin
              index_next = index + IW'(1);
            end
          end else begin
            count_next = count + CW'(1);
          end
        end
        default: state_next = BLANK;
      endcase
    end
  end

  // Outputs are registered from the next-cycle view, so the decoder nibble
  // for a freshly committed frame is already correct in digit 0's first
  // BLANK cycle.
  always_comb begin
    commit           = boundary & pending;
    active_data_next = commit ? staging_data : active_data;
    active_mask_next = commit ? staging_mask : active_mask;
    nibble_next      = active_data_next[{index_next, 2'b00} +: 4];
    enable_next      = '0;
    if (state_next == SHOW && !active_mask_next[index_next])
      enable_next = NUM_DIGITS'(1) << index_next;
    frame_start_next = ~running | boundary;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= BLANK;
      index         <= '0;
      count         <= '0;
      running       <= 1'b0;
      pending       <= 1'b0;
      staging_data  <= '0;
      staging_mask  <= '0;
      active_data   <= '0;
      active_mask   <= '1;
      binary_number <= '0;
      digit_enable  <= '0;
      load_ack      <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      state         <= state_next;
      index         <= index_next;
      count         <= count_next;
      running       <= 1'b1;
      active_data   <= active_data_next;
      active_mask   <= active_mask_next;
      binary_number <= nibble_next;
      digit_enable  <= enable_next;
      load_ack      <= commit;
      frame_start   <= frame_start_next;
      // A load coinciding with a commit is dropped: pending is still set.
      if (commit) begin
        pending <= 1'b0;
      end else if (load && !pending) begin
        staging_data <= data_in;
        staging_mask <= blank_in;
        pending      <= 1'b1;
      end
    end
  end

  assign load_ready = ~pending;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
//   Bench for display_scan_controller (4 digits, dwell 4, blank 2). A
//   frame-position model predicts every output each cycle; directed
//   sequences add literal expectations for loads, boundary loads, masking
//   and mid-scan reset, followed by a randomized load/reset phase.
module tb_display_scan_controller;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int B     = 2;
  localparam int SLOT  = B + D;
  localparam int FRAME = N * SLOT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load_ready, load_ack, frame_start;
  logic [3:0]  binary_number, digit_enable;

  int errors = 0;
  int checks = 0;

  display_scan_controller #(
    .NUM_DIGITS  (N),
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .load         (load),
    .load_ready   (load_ready),
    .data_in      (data_in),
    .blank_in     (blank_in),
    .load_ack     (load_ack),
    .binary_number(binary_number),
    .digit_enable (digit_enable),
    .frame_start  (frame_start)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the frame plus the two buffers.
  bit          m_valid = 1'b0;
  bit          m_run   = 1'b0;
  int          m_t     = 0;
  logic [15:0] m_ad = '0, m_sd = '0;
  logic [3:0]  m_am = '1, m_sm = '0;
  bit          m_pend = 1'b0, m_ack = 1'b0, m_fs = 1'b0, m_commit = 1'b0;
  int          e_digit, e_bin, e_en;

  // Outputs are checked on the falling edge, then the model advances using
  // the inputs the DUT will sample on the next rising edge.
  always @(negedge clock) begin
    if (m_valid) begin
      e_bin = 0;
      e_en  = 0;
      if (m_run) begin
        e_digit = m_t / SLOT;
        e_bin   = (m_ad >> (4 * e_digit)) & 16'hF;
        if ((m_t % SLOT) >= B && !m_am[e_digit]) e_en = 1 << e_digit;
      end
      chk("binary_number", binary_number, e_bin);
      chk("digit_enable", digit_enable, e_en);
      chk("load_ack", load_ack, m_ack);
      chk("frame_start", frame_start, m_fs);
      chk("load_ready", load_ready, !m_pend);
    end
    if (reset) begin
      m_valid = 1'b1; m_run = 1'b0; m_t = 0;
      m_pend = 1'b0; m_ack = 1'b0; m_fs = 1'b0;
      m_ad = '0; m_am = '1; m_sd = '0; m_sm = '0;
    end else if (m_valid) begin
      m_commit = 1'b0;
      if (!m_run) begin
        m_run = 1'b1;
        m_t   = 0;
        m_fs  = 1'b1;
      end else begin
        m_commit = (m_t == FRAME - 1) && m_pend;
        m_t      = (m_t + 1) % FRAME;
        m_fs     = (m_t == 0);
      end
      m_ack = m_commit;
      if (m_commit) begin
        m_ad = m_sd; m_am = m_sm; m_pend = 1'b0;
      end else if (load && !m_pend) begin
        m_sd = data_in; m_sm = blank_in; m_pend = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (frame_start) return;
    end
    chk("wait_frame_start", frame_start, 1);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      n++;
      if (load_ack) return;
    end
    chk("wait_load_ack", load_ack, 1);
  endtask

  task automatic show_check(input string name, input int wait_cycles,
                            input logic [3:0] bin, input logic [3:0] en);
    repeat (wait_cycles) tick();
    chk({name, "_en"}, digit_enable, en);
    if (en != 0) chk({name, "_bin"}, binary_number, bin);
  endtask

  int fs_count, en_seen, n, ack_seen;

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset: dark display, frame_start every FRAME cycles.
    fs_count = 0;
    en_seen  = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (i == 0) chk("first_frame_start", frame_start, 1);
      if (frame_start) fs_count++;
      if (digit_enable != 0) en_seen++;
    end
    chk("idle_frame_starts", fs_count, 2);
    chk("idle_dark", en_seen, 0);
    chk("idle_ready", load_ready, 1);

    // Mid-frame load, then a second load while pending (ignored).
    wait_fs();
    repeat (5) tick();
    load = 1'b1; data_in = 16'h3A71; blank_in = 4'b0000;
    tick();
    load = 1'b0;
    chk("ready_drop", load_ready, 0);
    load = 1'b1; data_in = 16'hFFFF;
    tick();
    load = 1'b0;
    wait_ack(n);
    chk("ack_after_mid_load", n, 17);
    show_check("d0", 2, 4'h1, 4'b0001);
    show_check("d1", 6, 4'h7, 4'b0010);
    show_check("d2", 6, 4'hA, 4'b0100);
    show_check("d3", 6, 4'h3, 4'b1000);

    // Load on the last cycle of the frame: commits one frame later.
    repeat (3) tick();
    load = 1'b1; data_in = 16'h1234; blank_in = 4'b0101;
    tick();
    load = 1'b0;
    chk("boundary_no_ack", load_ack, 0);
    chk("boundary_captured", load_ready, 0);
    wait_ack(n);
    chk("boundary_ack_latency", n, FRAME);
    show_check("m0", 2, 4'h4, 4'b0000);
    show_check("m1", 6, 4'h3, 4'b0010);
    show_check("m2", 6, 4'h2, 4'b0000);
    show_check("m3", 6, 4'h1, 4'b1000);

    // Reset during SHOW of digit 2 with a commit pending.
    wait_fs();
    load = 1'b1; data_in = 16'h5678; blank_in = 4'b0000;
    tick();
    load = 1'b0;
    repeat (13) tick();
    chk("pre_reset_pending", load_ready, 0);
    reset = 1'b1;
    tick();
    chk("rst_enable", digit_enable, 0);
    chk("rst_bin", binary_number, 0);
    chk("rst_ack", load_ack, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_ready", load_ready, 1);
    reset = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (load_ack) ack_seen++;
    end
    chk("no_ack_after_reset", ack_seen, 0);

    // Randomized loads with occasional resets.
    for (int i = 0; i < 900; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      data_in  = 16'($urandom);
      blank_in = 4'($urandom_range(0, 15));
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    load  = 1'b0;
    reset = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
